// File: rtl/beep_audio_pkg.sv
// Shared types and helpers for the beep sample mixer.
// Provides the sample width, saturation limits, the envelope and handshake
// state encodings and a saturating 32-bit signed adder.
package beep_audio_pkg;

    localparam int unsigned SAMPLE_W = 32;

    localparam logic [SAMPLE_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        E_IDLE,
        E_ATTACK,
        E_SUSTAIN,
        E_RELEASE
    } env_state_t;

    typedef enum logic {
        H_READ,
        H_WRITE
    } hs_state_t;

    // Saturating add result: sat is set when the value was clamped.
    typedef struct packed {
        logic                sat;
        logic [SAMPLE_W-1:0] value;
    } sat_res_t;

    // Signed add in 33 bits, clamped back into the 32-bit signed range.
    function automatic sat_res_t sat_add32(input logic [SAMPLE_W-1:0] a,
                                           input logic [SAMPLE_W-1:0] b);
        logic [SAMPLE_W:0] sum;
        sat_res_t          res;
        sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
        // Top two bits disagree only when the true sum left the 32-bit range.
        if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
            res.sat   = 1'b1;
            res.value = sum[SAMPLE_W] ? SAT_MIN : SAT_MAX;
        end else begin
            res.sat   = 1'b0;
            res.value = sum[SAMPLE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/beep_envelope.sv
// Linear attack/release envelope, advanced once per sample event.
// Ports: clk, reset (sync, active-high), step_en (sample event), tone_on
// (beep gate), env (registered level), env_nxt_c (level after this event).
module beep_envelope
    import beep_audio_pkg::*;
#(
    parameter logic [31:0] AMP_MAX   = 32'd50000000,
    parameter logic [31:0] RAMP_STEP = 32'd500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_en,
    input  logic                tone_on,
    output logic [SAMPLE_W-1:0] env,
    output logic [SAMPLE_W-1:0] env_nxt_c
);

    env_state_t        state;
    env_state_t        state_nxt;
    logic [SAMPLE_W:0] up_sum;
    logic [SAMPLE_W:0] dn_diff;
    logic [SAMPLE_W-1:0] up_lvl;
    logic [SAMPLE_W-1:0] dn_lvl;

    // Clamped one-step increment and decrement, 33 bits wide so nothing wraps.
    always_comb begin
        up_sum  = {1'b0, env} + {1'b0, RAMP_STEP};
        dn_diff = {1'b0, env} - {1'b0, RAMP_STEP};
        up_lvl  = (up_sum >= {1'b0, AMP_MAX}) ? AMP_MAX : up_sum[SAMPLE_W-1:0];
        dn_lvl  = dn_diff[SAMPLE_W] ? '0 : dn_diff[SAMPLE_W-1:0];
    end

    // Envelope next-state and level.
    always_comb begin
        state_nxt = state;
        env_nxt_c = env;
        if (step_en) begin
            case (state)
                E_IDLE: begin
                    env_nxt_c = '0;
                    if (tone_on) begin
                        env_nxt_c = up_lvl;
                        state_nxt = (up_lvl == AMP_MAX) ? E_SUSTAIN : E_ATTACK;
                    end
                end
                E_ATTACK: begin
                    if (!tone_on) begin
                        env_nxt_c = dn_lvl;
                        state_nxt = E_RELEASE;
                    end else begin
                        env_nxt_c = up_lvl;
                        if (up_lvl == AMP_MAX) state_nxt = E_SUSTAIN;
                    end
                end
                E_SUSTAIN: begin
                    env_nxt_c = AMP_MAX;
                    if (!tone_on) begin
                        env_nxt_c = dn_lvl;
                        state_nxt = E_RELEASE;
                    end
                end
                E_RELEASE: begin
                    if (tone_on) begin
                        // Resume from the current level rather than from zero.
                        env_nxt_c = up_lvl;
                        state_nxt = E_ATTACK;
                    end else begin
                        env_nxt_c = dn_lvl;
                        if (dn_lvl == '0) state_nxt = E_IDLE;
                    end
                end
                default: begin
                    env_nxt_c = '0;
                    state_nxt = E_IDLE;
                end
            endcase
        end
    end

    // State and level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= E_IDLE;
            env   <= '0;
        end else begin
            state <= state_nxt;
            env   <= env_nxt_c;
        end
    end

endmodule

// File: rtl/beep_sample_mixer.sv
// Beep sample mixer: envelopes the countdown beep, optionally mixes in the
// microphone, saturates and drives the Audio_Controller sample handshake.
// Ports: CLOCK_50, reset (sync, active-high); tone_on/tone_phase from the tone
// generator; mix_in_en; Audio_Controller handshake (audio_in_available,
// audio_out_allowed, read_audio_in, write_audio_out) and sample buses;
// env_level (envelope magnitude); clip (sticky saturation flag).
module beep_sample_mixer
    import beep_audio_pkg::*;
#(
    parameter logic [31:0] AMP_MAX   = 32'd50000000,
    parameter logic [31:0] RAMP_STEP = 32'd500000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                tone_on,
    input  logic                tone_phase,
    input  logic                mix_in_en,
    input  logic                audio_in_available,
    input  logic                audio_out_allowed,
    input  logic [SAMPLE_W-1:0] left_channel_audio_in,
    input  logic [SAMPLE_W-1:0] right_channel_audio_in,
    output logic                read_audio_in,
    output logic                write_audio_out,
    output logic [SAMPLE_W-1:0] left_channel_audio_out,
    output logic [SAMPLE_W-1:0] right_channel_audio_out,
    output logic [SAMPLE_W-1:0] env_level,
    output logic                clip
);

    hs_state_t           hs_state;
    hs_state_t           hs_nxt;
    logic [SAMPLE_W-1:0] env_nxt_c;
    logic [SAMPLE_W-1:0] tone_c;
    logic [SAMPLE_W-1:0] mic_l_c;
    logic [SAMPLE_W-1:0] mic_r_c;
    sat_res_t            mix_l_c;
    sat_res_t            mix_r_c;

    // Handshake next-state and strobes; both strobes are held off during reset.
    always_comb begin
        hs_nxt          = hs_state;
        read_audio_in   = 1'b0;
        write_audio_out = 1'b0;
        case (hs_state)
            H_READ: begin
                read_audio_in = audio_in_available & audio_out_allowed & ~reset;
                if (read_audio_in) hs_nxt = H_WRITE;
            end
            H_WRITE: begin
                write_audio_out = audio_out_allowed & ~reset;
                if (write_audio_out) hs_nxt = H_READ;
            end
            default: hs_nxt = H_READ;
        endcase
    end

    beep_envelope #(
        .AMP_MAX   (AMP_MAX),
        .RAMP_STEP (RAMP_STEP)
    ) u_envelope (
        .clk       (CLOCK_50),
        .reset     (reset),
        .step_en   (read_audio_in),
        .tone_on   (tone_on),
        .env       (env_level),
        .env_nxt_c (env_nxt_c)
    );

    // Signed square wave from the post-update envelope, plus optional mic.
    always_comb begin
        tone_c  = tone_phase ? env_nxt_c : (32'd0 - env_nxt_c);
        mic_l_c = mix_in_en ? left_channel_audio_in  : '0;
        mic_r_c = mix_in_en ? right_channel_audio_in : '0;
        mix_l_c = sat_add32(tone_c, mic_l_c);
        mix_r_c = sat_add32(tone_c, mic_r_c);
    end

    // Handshake state, output samples and sticky clip flag.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hs_state                <= H_READ;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
            clip                    <= 1'b0;
        end else begin
            hs_state <= hs_nxt;
            if (read_audio_in) begin
                left_channel_audio_out  <= mix_l_c.value;
                right_channel_audio_out <= mix_r_c.value;
                clip                    <= clip | mix_l_c.sat | mix_r_c.sat;
            end
        end
    end

endmodule

// File: tb/tb_beep_sample_mixer.sv
// Directed bench for beep_sample_mixer with AMP_MAX = 1000, RAMP_STEP = 250.
module tb_beep_sample_mixer;

    logic        CLOCK_50;
    logic        reset;
    logic        tone_on;
    logic        tone_phase;
    logic        mix_in_en;
    logic        audio_in_available;
    logic        audio_out_allowed;
    logic [31:0] left_channel_audio_in;
    logic [31:0] right_channel_audio_in;
    logic        read_audio_in;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic [31:0] env_level;
    logic        clip;

    int checks   = 0;
    int failures = 0;

    beep_sample_mixer #(
        .AMP_MAX   (32'd1000),
        .RAMP_STEP (32'd250)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .tone_on                 (tone_on),
        .tone_phase              (tone_phase),
        .mix_in_en               (mix_in_en),
        .audio_in_available      (audio_in_available),
        .audio_out_allowed       (audio_out_allowed),
        .left_channel_audio_in   (left_channel_audio_in),
        .right_channel_audio_in  (right_channel_audio_in),
        .read_audio_in           (read_audio_in),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .env_level               (env_level),
        .clip                    (clip)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // One full read/write sample cycle with available = allowed = 1.
    task automatic do_sample(input string tag, input int exp_l, input int exp_r, input int exp_env);
        #1;
        chk({tag, " read"}, 32'(read_audio_in), 32'd1);
        chk({tag, " write_in_read"}, 32'(write_audio_out), 32'd0);
        tick();
        chk({tag, " left"}, left_channel_audio_out, 32'(exp_l));
        chk({tag, " right"}, right_channel_audio_out, 32'(exp_r));
        chk({tag, " env"}, env_level, 32'(exp_env));
        chk({tag, " read_in_write"}, 32'(read_audio_in), 32'd0);
        chk({tag, " write"}, 32'(write_audio_out), 32'd1);
        tick();
    endtask

    initial begin
        reset                  = 1'b1;
        tone_on                = 1'b1;
        tone_phase             = 1'b1;
        mix_in_en              = 1'b0;
        audio_in_available     = 1'b0;
        audio_out_allowed      = 1'b0;
        left_channel_audio_in  = '0;
        right_channel_audio_in = '0;

        // Reset held 3 cycles with handshake inputs toggling.
        for (int i = 0; i < 3; i++) begin
            audio_in_available = i[0];
            audio_out_allowed  = ~i[0] | (i == 2);
            #1;
            chk("rst read", 32'(read_audio_in), 32'd0);
            chk("rst write", 32'(write_audio_out), 32'd0);
            tick();
        end
        chk("rst left", left_channel_audio_out, 32'd0);
        chk("rst right", right_channel_audio_out, 32'd0);
        chk("rst env", env_level, 32'd0);
        chk("rst clip", 32'(clip), 32'd0);

        // Attack to sustain; first read lands right after reset release.
        reset              = 1'b0;
        audio_in_available = 1'b1;
        audio_out_allowed  = 1'b1;
        do_sample("atk1", 250, 250, 250);
        do_sample("atk2", 500, 500, 500);
        do_sample("atk3", 750, 750, 750);
        do_sample("atk4", 1000, 1000, 1000);
        do_sample("sus1", 1000, 1000, 1000);

        // Release with negative phase down to idle.
        tone_on    = 1'b0;
        tone_phase = 1'b0;
        do_sample("rel1", -750, -750, 750);
        do_sample("rel2", -500, -500, 500);
        do_sample("rel3", -250, -250, 250);
        do_sample("rel4", 0, 0, 0);
        do_sample("idle", 0, 0, 0);

        // Re-attack during release resumes from the current level.
        tone_on    = 1'b1;
        tone_phase = 1'b1;
        do_sample("up1", 250, 250, 250);
        do_sample("up2", 500, 500, 500);
        do_sample("up3", 750, 750, 750);
        do_sample("up4", 1000, 1000, 1000);
        tone_on = 1'b0;
        do_sample("dn1", 750, 750, 750);
        do_sample("dn2", 500, 500, 500);
        tone_on = 1'b1;
        do_sample("resume", 750, 750, 750);
        do_sample("resume_sus", 1000, 1000, 1000);

        // Mixing without saturation.
        mix_in_en              = 1'b1;
        left_channel_audio_in  = 32'd100;
        right_channel_audio_in = 32'(-2000);
        do_sample("mix", 1100, -1000, 1000);
        chk("mix clip", 32'(clip), 32'd0);

        // Positive saturation on left.
        left_channel_audio_in  = 32'h7FFF_FF00;
        right_channel_audio_in = 32'd5;
        do_sample("satp", 32'h7FFF_FFFF, 1005, 1000);
        chk("satp clip", 32'(clip), 32'd1);

        // Negative saturation on right.
        tone_phase             = 1'b0;
        left_channel_audio_in  = 32'd0;
        right_channel_audio_in = 32'h8000_0010;
        do_sample("satn", -1000, 32'h8000_0000, 1000);

        // Clip stays set with small inputs.
        tone_phase             = 1'b1;
        left_channel_audio_in  = 32'd3;
        right_channel_audio_in = 32'(-7);
        do_sample("small", 1003, 993, 1000);
        chk("sticky clip", 32'(clip), 32'd1);

        // Backpressure: allowed drops right after the read for 6 cycles.
        mix_in_en = 1'b0;
        #1;
        chk("bp read", 32'(read_audio_in), 32'd1);
        tick();
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("bp write", 32'(write_audio_out), 32'd0);
            chk("bp read_held", 32'(read_audio_in), 32'd0);
            chk("bp left", left_channel_audio_out, 32'd1000);
            chk("bp right", right_channel_audio_out, 32'd1000);
            tick();
        end
        audio_out_allowed = 1'b1;
        #1;
        chk("bp write_pulse", 32'(write_audio_out), 32'd1);
        chk("bp no_read", 32'(read_audio_in), 32'd0);
        tick();
        do_sample("bp next", 1000, 1000, 1000);

        // Drive to env = 500 mid-attack, then reset while in H_WRITE.
        tone_on = 1'b0;
        do_sample("r6 d1", 750, 750, 750);
        do_sample("r6 d2", 500, 500, 500);
        do_sample("r6 d3", 250, 250, 250);
        do_sample("r6 d4", 0, 0, 0);
        tone_on = 1'b1;
        do_sample("r6 a1", 250, 250, 250);
        #1;
        chk("r6 read", 32'(read_audio_in), 32'd1);
        tick();
        chk("r6 env500", env_level, 32'd500);
        reset = 1'b1;
        #1;
        chk("r6 no_write", 32'(write_audio_out), 32'd0);
        chk("r6 no_read", 32'(read_audio_in), 32'd0);
        tick();
        chk("r6 env", env_level, 32'd0);
        chk("r6 left", left_channel_audio_out, 32'd0);
        chk("r6 right", right_channel_audio_out, 32'd0);
        chk("r6 clip", 32'(clip), 32'd0);
        reset = 1'b0;
        do_sample("r6 restart", 250, 250, 250);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beep_sample_mixer.md
Name: beep_sample_mixer

Overview:
- Downstream stage between the countdown tone generator and Audio_Controller.
- Consumes the raw beep gate (beep_active) and square-wave phase (snd).
- Applies a linear attack/release envelope per audio sample to remove clicks, and optionally mixes in the microphone samples.
- Saturates the result and drives the Audio_Controller read/write sample handshake with backpressure handling.

Parameters:
AMP_MAX, 32'd50000000, peak envelope magnitude (positive, < 2^31)
RAMP_STEP, 32'd500000, envelope increment/decrement per sample event

Ports:
CLOCK_50  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
tone_on  in  1  beep gate from countdown generator (beep_active)
tone_phase  in  1  square-wave phase (snd); 1 = positive half
mix_in_en  in  1  1 = add microphone input to output; 0 = tone only
audio_in_available  in  1  Audio_Controller has an input sample pair
audio_out_allowed  in  1  Audio_Controller output FIFO has space
left_channel_audio_in  in  32  signed mic sample, left
right_channel_audio_in  in  32  signed mic sample, right
read_audio_in  out  1  pop input sample pair (combinational)
write_audio_out  out  1  push output sample pair (combinational)
left_channel_audio_out  out  32  signed output sample, left (registered)
right_channel_audio_out  out  32  signed output sample, right (registered)
env_level  out  32  current envelope magnitude (registered)
clip  out  1  sticky: any output saturated since reset

Behaviour:
- Reset: all registered outputs 0; handshake state H_READ; envelope state E_IDLE; clip 0. Reset has priority over every other event, including mid-ramp and mid-handshake.
- Handshake FSM, two states:
  - H_READ: read_audio_in = audio_in_available & audio_out_allowed. On that cycle (the "sample event"):
    - capture the inputs;
    - update the envelope;
    - register the new left/right outputs;
    - go to H_WRITE.
  - H_WRITE: write_audio_out = audio_out_allowed. When it is 1, return to H_READ. Otherwise hold, with outputs stable and read_audio_in = 0.
  - read_audio_in and write_audio_out are never 1 in the same cycle.
  - Minimum read-to-write latency is 1 cycle; the minimum period is 2 cycles per sample.
- Envelope FSM, evaluated only on sample events; tone_on is sampled at the event:
  - E_IDLE: env = 0. If tone_on = 1, then env = min(RAMP_STEP, AMP_MAX) and go to E_ATTACK, or to E_SUSTAIN if AMP_MAX has been reached.
  - E_ATTACK: if tone_on = 0, go to E_RELEASE and apply a decrement this event. Otherwise env = min(env + RAMP_STEP, AMP_MAX); on reaching AMP_MAX, go to E_SUSTAIN.
  - E_SUSTAIN: env = AMP_MAX. If tone_on = 0, go to E_RELEASE with a decrement this event.
  - E_RELEASE: if tone_on = 1, go to E_ATTACK with an increment from the current level (no reset to 0). Otherwise env = max(env - RAMP_STEP, 0); on reaching 0, go to E_IDLE.
  - Arithmetic is done in 33 bits so there is no wrap.
- Sample: tone = tone_phase ? +env : -env, where env is the post-update value.
- Output: out = sat32(tone + (mix_in_en ? channel_in : 0)), per channel.
  - sat32 clamps the 33-bit signed sum to [0x80000000, 0x7FFFFFFF].
  - If either channel clamps, clip is set to 1 and is cleared only by reset.
- env_level updates on sample events only.

Decomposition:
- Package beep_audio_pkg: SAMPLE_W = 32; SAT_MAX/SAT_MIN constants; enum env_state_t {E_IDLE, E_ATTACK, E_SUSTAIN, E_RELEASE}; enum hs_state_t {H_READ, H_WRITE}; function sat_add32(signed 32, signed 32) returning {sat flag, 32-bit result}.
- Sub-module beep_envelope: holds the envelope FSM and level; inputs are the step enable (sample event) and tone_on; output is env.
- The top level holds the handshake FSM, mixing, saturation and the clip register.

Test Plan:
All scenarios use AMP_MAX = 1000 and RAMP_STEP = 250.
1. Reset held 3 cycles with handshake inputs toggling -> all outputs 0, read_audio_in/write_audio_out 0 while reset is high; first read_audio_in occurs in the cycle after reset deasserts, with both available and allowed at 1.
2. tone_on = 1, tone_phase = 1, mix_in_en = 0, available = allowed = 1 for 5 sample events -> left/right outputs 250, 500, 750, 1000, 1000; env_level reaches 1000 at event 4; read/write alternate each cycle.
3. From sustain, tone_on = 0, tone_phase = 0 -> outputs -750, -500, -250, 0, then 0; envelope in E_IDLE after the 4th event. Re-asserting tone_on at env = 500 during release -> next output is 750 (no restart from 0).
4. Saturation: mix_in_en = 1, left_in = 0x7FFFFF00, env = 1000, phase = 1 -> left out 0x7FFFFFFF, clip = 1. Then right_in = 0x80000010, phase = 0 -> right out 0x80000000. clip stays 1 afterwards even with small inputs.
5. Backpressure: audio_out_allowed drops to 0 the cycle after a read for 6 cycles -> write_audio_out 0, no further read, outputs stable. When allowed returns, write_audio_out pulses for exactly 1 cycle, then the next read is permitted.
6. Reset asserted mid-attack (env = 500) while in H_WRITE -> next cycle env_level 0, outputs 0, no write pulse. After release of reset, the ramp restarts at 250.
